// File: rtl/riscv_core_bp_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout,
// 2-bit counter encodings and the saturating counter update.
package riscv_core_bp_pkg;

  // Entry fields are sized for the widest supported address; narrower
  // instances zero-extend tags and targets into them.
  localparam int BP_MAXW = 64;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [BP_MAXW-1:0] tag;
    logic [BP_MAXW-1:0] target;
    ctr_t               ctr;
  } bp_entry_t;

  // Saturating up/down step of the direction counter.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_core_bp_btb.sv
// Direct-mapped BTB storage: flop array with two combinational read ports
// (fetch lookup, execute training) and one synchronous write port.
module riscv_core_bp_btb
  import riscv_core_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] i_rd_a_idx,
  output bp_entry_t       o_rd_a_entry,
  input  logic [IDXW-1:0] i_rd_b_idx,
  output bp_entry_t       o_rd_b_entry,
  input  logic            i_wr_en,
  input  logic [IDXW-1:0] i_wr_idx,
  input  bp_entry_t       i_wr_entry
);

  localparam bp_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  bp_entry_t mem_q [ENTRIES];
  bp_entry_t mem_d [ENTRIES];

  // Reads see the stored contents only; a same-cycle write is not bypassed.
  assign o_rd_a_entry = mem_q[i_rd_a_idx];
  assign o_rd_b_entry = mem_q[i_rd_b_idx];

  // Next-state of the array: copy, then overlay the single write.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) mem_d[i] = mem_q[i];
    if (i_wr_en) mem_d[i_wr_idx] = i_wr_entry;
  end

  // Table register; async reset clears every entry and drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= RESET_ENTRY;
    end else begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/riscv_core_branch_predictor.sv
// Branch predictor top: BTB lookup for fetch, resolution compare and
// recovery address for execute, table training and statistics counters.
module riscv_core_branch_predictor
  import riscv_core_bp_pkg::*;
#(
  parameter int ADDRLEN = 64,
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDRLEN-1:0] i_bp_fetch_PC,
  output logic               o_bp_valid,
  output logic               o_bp_isTaken_BP,
  output logic [ADDRLEN-1:0] o_bp_predictedAddr,
  input  logic               i_bp_ex_valid,
  input  logic [ADDRLEN-1:0] i_bp_ex_PC,
  input  logic               i_bp_ex_taken,
  input  logic [ADDRLEN-1:0] i_bp_ex_target,
  input  logic               i_bp_ex_pred_taken,
  input  logic [ADDRLEN-1:0] i_bp_ex_pred_addr,
  output logic               o_bp_misprediction,
  output logic [ADDRLEN-1:0] o_bp_recoveredAddr,
  output logic [31:0]        o_bp_branch_count,
  output logic [31:0]        o_bp_mispredict_count
);

  logic [IDXW-1:0]    fetch_idx, ex_idx;
  logic [BP_MAXW-1:0] fetch_tag, ex_tag;
  bp_entry_t          fetch_entry, ex_entry, wr_entry;
  logic               fetch_hit, ex_hit, wr_en;
  logic [31:0]        branch_count_q, branch_count_d;
  logic [31:0]        mispredict_count_q, mispredict_count_d;

  // Instructions are word aligned; the byte offset plays no part in indexing.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_bp_fetch_PC[1:0], i_bp_ex_PC[1:0]};

  assign fetch_idx = i_bp_fetch_PC[IDXW+1:2];
  assign ex_idx    = i_bp_ex_PC[IDXW+1:2];
  assign fetch_tag = BP_MAXW'(i_bp_fetch_PC[ADDRLEN-1:IDXW+2]);
  assign ex_tag    = BP_MAXW'(i_bp_ex_PC[ADDRLEN-1:IDXW+2]);

  riscv_core_bp_btb #(
    .ENTRIES (ENTRIES),
    .IDXW    (IDXW)
  ) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rd_a_idx   (fetch_idx),
    .o_rd_a_entry (fetch_entry),
    .i_rd_b_idx   (ex_idx),
    .o_rd_b_entry (ex_entry),
    .i_wr_en      (wr_en),
    .i_wr_idx     (ex_idx),
    .i_wr_entry   (wr_entry)
  );

  // Fetch-side lookup; a miss forces direction and target to zero.
  always_comb begin
    fetch_hit          = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    o_bp_valid         = fetch_hit;
    o_bp_isTaken_BP    = fetch_hit && fetch_entry.ctr[1];
    o_bp_predictedAddr = fetch_hit ? ADDRLEN'(fetch_entry.target) : '0;
  end

  // Resolution check and redirect address for the instruction in EX.
  always_comb begin
    o_bp_misprediction = 1'b0;
    o_bp_recoveredAddr = '0;
    if (i_bp_ex_valid) begin
      o_bp_misprediction = (i_bp_ex_taken != i_bp_ex_pred_taken) ||
                           (i_bp_ex_taken && i_bp_ex_pred_taken &&
                            (i_bp_ex_target != i_bp_ex_pred_addr));
    end
    if (o_bp_misprediction) begin
      o_bp_recoveredAddr = i_bp_ex_taken ? i_bp_ex_target : i_bp_ex_PC + ADDRLEN'(4);
    end
  end

  // Training write: update a hit in place, allocate only on a taken miss.
  always_comb begin
    ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);
    wr_en    = 1'b0;
    wr_entry = ex_entry;
    if (i_bp_ex_valid) begin
      if (ex_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next(ex_entry.ctr, i_bp_ex_taken);
        if (i_bp_ex_taken) wr_entry.target = BP_MAXW'(i_bp_ex_target);
      end else if (i_bp_ex_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = ex_tag;
        wr_entry.target = BP_MAXW'(i_bp_ex_target);
        wr_entry.ctr    = CTR_WT;
      end
    end
  end

  // Statistics next-state; both counters wrap naturally at 32 bits.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (i_bp_ex_valid) branch_count_d = branch_count_q + 32'd1;
    if (o_bp_misprediction) mispredict_count_d = mispredict_count_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign o_bp_branch_count     = branch_count_q;
  assign o_bp_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Directed bench for riscv_core_branch_predictor: a vector table applied one
// per cycle (state carries across rows), plus hand-written reset sequences.
module tb_riscv_core_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [63:0] fetch_pc;
  logic        bp_valid;
  logic        bp_taken;
  logic [63:0] bp_addr;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        pred_taken;
  logic [63:0] pred_addr;
  logic        mispred;
  logic [63:0] rec_addr;
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  int checks   = 0;
  int failures = 0;

  riscv_core_branch_predictor #(
    .ADDRLEN (64),
    .ENTRIES (16)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_bp_fetch_PC         (fetch_pc),
    .o_bp_valid            (bp_valid),
    .o_bp_isTaken_BP       (bp_taken),
    .o_bp_predictedAddr    (bp_addr),
    .i_bp_ex_valid         (ex_valid),
    .i_bp_ex_PC            (ex_pc),
    .i_bp_ex_taken         (ex_taken),
    .i_bp_ex_target        (ex_target),
    .i_bp_ex_pred_taken    (pred_taken),
    .i_bp_ex_pred_addr     (pred_addr),
    .o_bp_misprediction    (mispred),
    .o_bp_recoveredAddr    (rec_addr),
    .o_bp_branch_count     (br_cnt),
    .o_bp_mispredict_count (mp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] fpc;
    logic        exv;
    logic [63:0] epc;
    logic        etk;
    logic [63:0] etg;
    logic        ptk;
    logic [63:0] pad;
    logic        x_valid;
    logic        x_taken;
    logic [63:0] x_addr;
    logic        x_mp;
    logic [63:0] x_rec;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [63:0] fpc, input logic exv, input logic [63:0] epc,
                              input logic etk, input logic [63:0] etg, input logic ptk,
                              input logic [63:0] pad, input logic x_valid, input logic x_taken,
                              input logic [63:0] x_addr, input logic x_mp, input logic [63:0] x_rec);
    vec_t v;
    v.fpc = fpc; v.exv = exv; v.epc = epc; v.etk = etk; v.etg = etg; v.ptk = ptk; v.pad = pad;
    v.x_valid = x_valid; v.x_taken = x_taken; v.x_addr = x_addr; v.x_mp = x_mp; v.x_rec = x_rec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic [63:0] pc, input logic tk,
                          input logic [63:0] tg, input logic ptk, input logic [63:0] pad);
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg; pred_taken = ptk; pred_addr = pad;
  endtask

  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    // fetch_pc, ex_valid, ex_pc, taken, target, pred_taken, pred_addr | valid, taken, addr, mp, rec
    vecs[0]  = mk(64'h1000, 0, 64'h0,    0, 64'h0,    0, 64'h0,    0, 0, 64'h0,    0, 64'h0);
    vecs[1]  = mk(64'h1000, 1, 64'h1000, 1, 64'h2000, 0, 64'h0,    0, 0, 64'h0,    1, 64'h2000);
    vecs[2]  = mk(64'h1000, 1, 64'h1000, 0, 64'h0,    1, 64'h2000, 1, 1, 64'h2000, 1, 64'h1004);
    vecs[3]  = mk(64'h1000, 1, 64'h1000, 0, 64'h0,    0, 64'h0,    1, 0, 64'h2000, 0, 64'h0);
    vecs[4]  = mk(64'h1000, 1, 64'h1000, 0, 64'h0,    0, 64'h0,    1, 0, 64'h2000, 0, 64'h0);
    vecs[5]  = mk(64'h1000, 0, 64'h0,    0, 64'h0,    0, 64'h0,    1, 0, 64'h2000, 0, 64'h0);
    vecs[6]  = mk(64'h1000, 1, 64'h1000, 1, 64'h3000, 1, 64'h2000, 1, 0, 64'h2000, 1, 64'h3000);
    vecs[7]  = mk(64'h1000, 1, 64'h1000, 1, 64'h3000, 1, 64'h3000, 1, 0, 64'h3000, 0, 64'h0);
    vecs[8]  = mk(64'h1000, 0, 64'h0,    0, 64'h0,    0, 64'h0,    1, 1, 64'h3000, 0, 64'h0);
    vecs[9]  = mk(64'h1040, 1, 64'h1040, 1, 64'h5000, 0, 64'h0,    0, 0, 64'h0,    1, 64'h5000);
    vecs[10] = mk(64'h1000, 0, 64'h0,    0, 64'h0,    0, 64'h0,    0, 0, 64'h0,    0, 64'h0);
    vecs[11] = mk(64'h1040, 0, 64'h0,    0, 64'h0,    0, 64'h0,    1, 1, 64'h5000, 0, 64'h0);
    vecs[12] = mk(TOP_PC,   1, TOP_PC,   0, 64'h0,    1, 64'h1234, 0, 0, 64'h0,    1, 64'h0);
    vecs[13] = mk(TOP_PC,   0, 64'h0,    0, 64'h0,    0, 64'h0,    0, 0, 64'h0,    0, 64'h0);
    vecs[14] = mk(64'h1040, 0, 64'h2000, 1, 64'h9000, 0, 64'h0,    1, 1, 64'h5000, 0, 64'h0);
    vecs[15] = mk(64'h2000, 0, 64'h0,    0, 64'h0,    0, 64'h0,    0, 0, 64'h0,    0, 64'h0);
    vecs[16] = mk(64'h1042, 0, 64'h0,    0, 64'h0,    0, 64'h0,    1, 1, 64'h5000, 0, 64'h0);

    rst_n    = 1'b0;
    fetch_pc = 64'h1000;
    drive_ex(0, 64'h0, 0, 64'h0, 0, 64'h0);
    repeat (2) @(negedge clk);
    chk("rst_valid_during", {63'd0, bp_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("reset_valid", {63'd0, bp_valid}, 64'd0);
    chk("reset_taken", {63'd0, bp_taken}, 64'd0);
    chk("reset_addr", bp_addr, 64'd0);
    chk("reset_br_cnt", {32'd0, br_cnt}, 64'd0);
    chk("reset_mp_cnt", {32'd0, mp_cnt}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      fetch_pc = vecs[i].fpc;
      drive_ex(vecs[i].exv, vecs[i].epc, vecs[i].etk, vecs[i].etg, vecs[i].ptk, vecs[i].pad);
      #2;
      chk($sformatf("v%0d_valid", i), {63'd0, bp_valid}, {63'd0, vecs[i].x_valid});
      chk($sformatf("v%0d_taken", i), {63'd0, bp_taken}, {63'd0, vecs[i].x_taken});
      chk($sformatf("v%0d_addr", i), bp_addr, vecs[i].x_addr);
      chk($sformatf("v%0d_mispred", i), {63'd0, mispred}, {63'd0, vecs[i].x_mp});
      chk($sformatf("v%0d_recovered", i), rec_addr, vecs[i].x_rec);
    end

    // 8 resolving rows above, 5 of them mispredicted.
    @(negedge clk);
    drive_ex(0, 64'h0, 0, 64'h0, 0, 64'h0);
    #2;
    chk("stat_br_cnt", {32'd0, br_cnt}, 64'd8);
    chk("stat_mp_cnt", {32'd0, mp_cnt}, 64'd5);

    // Reset asserted while a taken allocate is pending: write discarded, table cleared.
    @(negedge clk);
    fetch_pc = 64'h1040;
    drive_ex(1, 64'h3000, 1, 64'h7000, 0, 64'h0);
    #2;
    chk("pre_rst_hit", {63'd0, bp_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {63'd0, bp_valid}, 64'd0);
    chk("rst_async_addr", bp_addr, 64'd0);
    chk("rst_async_br_cnt", {32'd0, br_cnt}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    drive_ex(0, 64'h0, 0, 64'h0, 0, 64'h0);
    rst_n = 1'b1;
    fetch_pc = 64'h3000;
    #2;
    chk("rst_drop_write", {63'd0, bp_valid}, 64'd0);
    chk("rst_mp_cnt", {32'd0, mp_cnt}, 64'd0);

    // Training resumes after reset; write visible on the following cycle only.
    @(negedge clk);
    drive_ex(1, 64'h3000, 1, 64'h7000, 0, 64'h0);
    #2;
    chk("post_rst_same_cycle", {63'd0, bp_valid}, 64'd0);
    @(negedge clk);
    drive_ex(0, 64'h0, 0, 64'h0, 0, 64'h0);
    #2;
    chk("post_rst_hit", {63'd0, bp_valid}, 64'd1);
    chk("post_rst_taken", {63'd0, bp_taken}, 64'd1);
    chk("post_rst_addr", bp_addr, 64'h7000);
    chk("post_rst_br_cnt", {32'd0, br_cnt}, 64'd1);
    chk("post_rst_mp_cnt", {32'd0, mp_cnt}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
